// File: rtl/alu_pkg.sv
// Shared op encodings, FSM states and helpers for the execute-stage ALU/MDU.
// The M-extension ops are built only when ALU_MULDIV_EN is defined.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_AND    = 5'b00000,
    ALU_OR     = 5'b00001,
    ALU_ADD    = 5'b00010,
    ALU_XOR    = 5'b00011,
    ALU_SLL    = 5'b00100,
    ALU_SLTU   = 5'b00101,
    ALU_SUB    = 5'b00110,
    ALU_SUBU   = 5'b00111,
    ALU_SRL    = 5'b01000,
    ALU_LUI    = 5'b01001,
    ALU_SLT    = 5'b01010,
    ALU_SRA    = 5'b01100,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_mop(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine: one bit per step on operand magnitudes,
// sign correction applied combinationally on the outputs.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              a_signed,
  input  logic              b_signed,
  input  logic              is_div,
  output logic              done,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, d_q, a_q;
  logic            neg_ab_q, neg_a_q, div_zero_q, div_mode_q;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ok;

  assign a_neg = a_signed & a[XLEN-1];
  assign b_neg = b_signed & b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // lo_q holds the multiplier (mul) or the dividend being shifted into quotient (div)
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : {(XLEN+1){1'b0}});
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, d_q};
  assign div_ok   = !div_diff[XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (start) cnt_q <= '0;
    else if (step)  cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      hi_q       <= '0;
      lo_q       <= mag_a;
      d_q        <= mag_b;
      a_q        <= a;
      neg_ab_q   <= a_neg ^ b_neg;
      neg_a_q    <= a_neg;
      div_zero_q <= (b == '0);
      div_mode_q <= is_div;
    end else if (step) begin
      if (div_mode_q) begin
        hi_q <= div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], div_ok};
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign done = (cnt_q == LAST);
  assign prod = neg_ab_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  // Divide-by-zero bypasses sign correction so the result is exactly all-ones / dividend
  assign quot = div_zero_q ? '1  : (neg_ab_q ? -lo_q : lo_q);
  assign rem  = div_zero_q ? a_q : (neg_a_q  ? -hi_q : hi_q);

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with registered, handshaked result and optional iterative
// multiply/divide (enabled by defining ALU_MULDIV_EN).
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            con_bgt,
  output logic            con_blt,
  output logic            illegal,
  output logic            busy
);

  mdu_state_e state_q, state_d;
  logic       accept, take_mop;

  logic [XLEN-1:0] diff;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] base_res;
  logic            base_zero, base_gt, base_lt, base_ill;

  assign accept = in_valid && in_ready;
  assign diff   = src_a - src_b;
  assign sh     = src_b[SHW-1:0];

  always_comb begin
    base_res  = '0;
    base_zero = 1'b0;
    base_gt   = 1'b0;
    base_lt   = 1'b0;
    base_ill  = 1'b0;
    case (alu_op_e'(op))
      ALU_AND:  base_res = src_a & src_b;
      ALU_OR:   base_res = src_a | src_b;
      ALU_ADD:  base_res = src_a + src_b;
      ALU_XOR:  base_res = src_a ^ src_b;
      ALU_SLL:  base_res = src_a << sh;
      ALU_SRL:  base_res = src_a >> sh;
      ALU_SRA:  base_res = XLEN'($signed(src_a) >>> sh);
      ALU_LUI:  base_res = src_b;
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SUB: begin
        base_res  = diff;
        base_zero = (diff == '0);
        base_gt   = $signed(src_a) > $signed(src_b);
        base_lt   = $signed(src_a) < $signed(src_b);
      end
      ALU_SUBU: begin
        base_res  = diff;
        base_zero = (diff == '0);
        base_gt   = src_a > src_b;
        base_lt   = src_a < src_b;
      end
      default:  base_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [2:0]        mop_q;
  logic              mdu_done;
  logic              a_signed, b_signed;
  logic [2*XLEN-1:0] mdu_prod;
  logic [XLEN-1:0]   mdu_quot, mdu_rem, mdu_res;

  assign take_mop = accept && is_mop(op);
  // div/rem: signed unless op[0]; mul: MULH is s*s, MULHSU is s*u, MUL/MULHU unsigned
  assign a_signed = op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign b_signed = op[2] ? !op[0] : (op[1:0] == 2'b01);

  always_ff @(posedge clk) begin
    if (take_mop) mop_q <= op[2:0];
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (take_mop),
    .step     (state_q == CALC),
    .a        (src_a),
    .b        (src_b),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .is_div   (op[2]),
    .done     (mdu_done),
    .prod     (mdu_prod),
    .quot     (mdu_quot),
    .rem      (mdu_rem)
  );

  always_comb begin
    mdu_res = '0;
    case (mop_q)
      3'b000:                 mdu_res = mdu_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: mdu_res = mdu_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         mdu_res = mdu_quot;
      default:                mdu_res = mdu_rem;
    endcase
  end
`else
  assign take_mop = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = IDLE;
`ifdef ALU_MULDIV_EN
    case (state_q)
      IDLE:    state_d = take_mop ? CALC : IDLE;
      CALC:    state_d = mdu_done ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`endif
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid || out_ready);
`ifdef ALU_MULDIV_EN
    busy     = (state_q == CALC) || (state_q == DONE);
`else
    busy     = 1'b0;
`endif
  end

  // Output register: a same-cycle accept overrides the drain so out_valid stays high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      con_bgt   <= 1'b0;
      con_blt   <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !take_mop) begin
      out_valid <= 1'b1;
      result    <= base_res;
      zero      <= base_zero;
      con_bgt   <= base_gt;
      con_blt   <= base_lt;
      illegal   <= base_ill;
`ifdef ALU_MULDIV_EN
    end else if (state_q == DONE) begin
      out_valid <= 1'b1;
      result    <= mdu_res;
      zero      <= 1'b0;
      con_bgt   <= 1'b0;
      con_blt   <= 1'b0;
      illegal   <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu; M-op vectors are exercised when ALU_MULDIV_EN is defined.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            con_bgt;
  logic            con_blt;
  logic            illegal;
  logic            busy;

  int n_asrt = 0;
  int n_fail = 0;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .con_bgt   (con_bgt),
    .con_blt   (con_blt),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, wait (bounded) for acceptance, then scramble the inputs.
  task automatic offer(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    while (!in_ready && k < 60) begin
      step1();
      k++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    step1();
    in_valid = 1'b0;
    op = 5'b11111; src_a = '1; src_b = '1;
  endtask

  // Base op: result and {out_valid, illegal, zero, con_bgt, con_blt} one cycle after accept.
  task automatic base_chk(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic [4:0] eflags);
    offer(o, a, b);
    chk(tag, result, exp);
    chk({tag, "_flags"}, {27'b0, out_valid, illegal, zero, con_bgt, con_blt}, {27'b0, eflags});
  endtask

`ifdef ALU_MULDIV_EN
  task automatic m_chk(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int k;
    offer(o, a, b);
    for (k = 1; k <= 40; k++) begin
      step1();
      if (k == 5) chk({tag, "_stall"}, {30'b0, in_ready, busy}, 32'd1);
      if (out_valid) break;
    end
    chk({tag, "_lat"}, k, 32'd33);
    chk(tag, result, exp);
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; out_ready = 1'b1;
    repeat (3) step1();
    chk("rst_outs", {26'b0, out_valid, illegal, zero, con_bgt, con_blt, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step1();

    base_chk("add_ovf", ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b10000);
    base_chk("sub_neg", ALU_SUB,  32'hFFFFFFFB, 32'h00000003, 32'hFFFFFFF8, 5'b10001);
    base_chk("subu_lt", ALU_SUBU, 32'h00000003, 32'hFFFFFFFB, 32'h00000008, 5'b10001);
    base_chk("sub_eq",  ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 5'b10100);
    base_chk("subu_gt", ALU_SUBU, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 5'b10010);
    base_chk("add_z",   ALU_ADD,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b10000);
    base_chk("and",     ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b10000);
    base_chk("or",      ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 5'b10000);
    base_chk("xor",     ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'b10000);
    base_chk("sll",     ALU_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 5'b10000);
    base_chk("srl",     ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 5'b10000);
    base_chk("sra",     ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 5'b10000);
    base_chk("slt",     ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b10000);
    base_chk("sltu",    ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000);
    base_chk("lui",     ALU_LUI,  32'hDEADBEEF, 32'h12345000, 32'h12345000, 5'b10000);
    base_chk("ill_op",  5'b01011, 32'h00000001, 32'h00000002, 32'h00000000, 5'b11000);
    step1();
    chk("drain", {31'b0, out_valid}, 32'd0);

    // Backpressure: result held while the consumer stalls.
    out_ready = 1'b0;
    base_chk("bp_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 5'b10000);
    op = ALU_ADD; src_a = 32'd10; src_b = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_result", result, 32'd5);
      chk("hold_ready", {30'b0, in_ready, out_valid}, 32'd1);
      step1();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", {31'b0, in_ready}, 32'd1);
    step1();
    in_valid = 1'b0;
    chk("release_result", result, 32'd30);
    chk("release_valid", {31'b0, out_valid}, 32'd1);
    step1();
    chk("release_drain", {31'b0, out_valid}, 32'd0);

`ifdef ALU_MULDIV_EN
    m_chk("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    m_chk("mul",    ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    m_chk("mulh",   ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    m_chk("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    m_chk("div_ovf", ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    m_chk("rem_ovf", ALU_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    m_chk("div_neg", ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    m_chk("rem_neg", ALU_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
    m_chk("divu_z",  ALU_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF);
    m_chk("remu_z",  ALU_REMU,  32'h00000007, 32'h00000000, 32'h00000007);

    // Reset in the middle of a divide aborts it at once.
    offer(ALU_DIV, 32'd100, 32'd7);
    repeat (9) step1();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {26'b0, out_valid, illegal, zero, con_bgt, con_blt, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    step1();
    rst_n = 1'b1;
    step1();
    base_chk("post_rst_add", ALU_ADD, 32'd2, 32'd2, 32'd4, 5'b10000);
`else
    base_chk("mul_ill", ALU_MUL, 32'd3, 32'd4, 32'd0, 5'b11000);
    chk("mul_ill_busy", {31'b0, busy}, 32'd0);
    base_chk("div_ill", ALU_DIV, 32'd8, 32'd2, 32'd0, 5'b11000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
